// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry,
// common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int DATA_BITS = 8;
  // Frame bit positions: start = 0, data = 1..DATA_BITS, stop follows.
  localparam int STOP_BIT_IDX = DATA_BITS + 1;
  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous serial line plus a
// one-clock falling-edge detector on the synchronised value.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async,
  output logic rx_sync,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   rx_prev;

  // Stages reset to 1 so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages  <= '1;
      rx_prev <= 1'b1;
    end else begin
      stages  <= {stages[SYNC_STAGES-2:0], rx_async};
      rx_prev <= stages[SYNC_STAGES-1];
    end
  end

  assign rx_sync = stages[SYNC_STAGES-1];
  assign rx_fall = rx_prev & ~rx_sync;

endmodule

// File: rtl/my_uart_rx.sv
// RS232 byte receiver: samples the line on baud-generator mid-bit pulses,
// reports good bytes via rx_done and bad stop bits via frame_err.
module my_uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_done,
  output logic       frame_err
);

  rx_state_e              state, state_nx;
  logic [2:0]             bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0]   shift, shift_nx;
  logic [7:0]             rx_data_nx;
  logic                   busy, busy_nx;
  logic                   done_nx, ferr_nx;
  logic                   rx_line, rx_fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_async(uart_rx),
    .rx_sync (rx_line),
    .rx_fall (rx_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      busy      <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      rx_data   <= rx_data_nx;
      busy      <= busy_nx;
      rx_done   <= done_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    rx_data_nx = rx_data;
    busy_nx    = busy;
    done_nx    = 1'b0;
    ferr_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_nx = START;
          busy_nx  = 1'b1;
        end
      end
      // A line already high again at mid start bit was only a glitch.
      START: begin
        if (clk_bps) begin
          if (!rx_line) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end
      end
      DATA: begin
        if (clk_bps) begin
          shift_nx[bit_cnt] = rx_line;
          if (bit_cnt == LAST_DATA_IDX) begin
            state_nx   = STOP;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (clk_bps) begin
          busy_nx = 1'b0;
          if (rx_line) begin
            rx_data_nx = shift;
            done_nx    = 1'b1;
            state_nx   = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      // A stuck-low line must return high before a new frame can start.
      WAIT_IDLE: begin
        if (rx_line) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  assign bps_start = busy;
  assign rx_int    = busy;

endmodule

// File: tb/tb_my_uart_rx.sv
// Scoreboard bench for my_uart_rx: directed frames push expected events,
// a negedge monitor pops and compares on every rx_done / frame_err.
module tb_my_uart_rx;

  localparam int BIT_CLKS = 16;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_done;
  logic       frame_err;

  logic [3:0] baud_cnt;
  logic       inject = 1'b0;
  logic       gen_pulse;

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       exp_q[$];
  exp_t       mon_exp;
  logic [7:0] last_good = 8'h00;
  logic       prev_busy = 1'b0;
  logic       prev_done = 1'b0;

  my_uart_rx #(
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .clk_bps  (clk_bps),
    .bps_start(bps_start),
    .rx_data  (rx_data),
    .rx_int   (rx_int),
    .rx_done  (rx_done),
    .frame_err(frame_err)
  );

  always #20 clk = ~clk;

  // Baud generator model: mid-bit pulse every BIT_CLKS while requested.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_cnt <= 4'd0;
    else if (!bps_start) baud_cnt <= 4'd0;
    else baud_cnt <= baud_cnt + 4'd1;
  end

  assign gen_pulse = bps_start && (baud_cnt == 4'd8);
  assign clk_bps   = gen_pulse | inject;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back('{is_err: 1'b0, data: data});
      last_good = data;
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: last_good});
    end
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    checkOutput("busy_during_frame", {30'd0, bps_start, rx_int}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulseInject();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (prev_done) checkOutput("done_pulse_width", {31'd0, rx_done}, 32'd0);
    if (rx_done || frame_err) begin
      checkOutput("done_ferr_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got done=%0b ferr=%0b data=%0h, expected none",
                 rx_done, frame_err, rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("event_kind", {31'd0, frame_err}, {31'd0, mon_exp.is_err});
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mon_exp.data});
        checkOutput("busy_falls_with_event", {29'd0, prev_busy, bps_start, rx_int}, 32'd4);
      end
    end
    prev_busy = bps_start;
    prev_done = rx_done;
  end

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("reset_state", {20'd0, bps_start, rx_int, rx_done, frame_err, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // clk_bps while idle is ignored
    for (int i = 0; i < 4; i++) begin
      pulseInject();
      checkOutput("idle_inject", {20'd0, bps_start, rx_int, rx_done, frame_err, rx_data}, 32'd0);
    end

    applyStimulus(8'h55, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);

    // Start glitch: three clocks low, then high before mid start bit
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("glitch_busy_set", {30'd0, bps_start, rx_int}, 32'd3);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_abort", {20'd0, bps_start, rx_int, rx_done, frame_err, rx_data}, 32'h055);

    // Framing error, then line stuck low for two more bit periods
    applyStimulus(8'hA3, 1'b0);
    for (int p = 0; p < 2; p++) begin
      repeat (BIT_CLKS / 2) @(negedge clk);
      pulseInject();
      repeat (BIT_CLKS / 2 - 2) @(negedge clk);
      checkOutput("wait_idle_no_frame", {22'd0, bps_start, rx_int, rx_data}, 32'h055);
    end
    uart_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("ferr_recovered", {22'd0, bps_start, rx_int, rx_data}, 32'h055);

    applyStimulus(8'h0F, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    checkOutput("back_to_back_last", {24'd0, rx_data}, 32'hF0);

    // Reset in the middle of data bit 4 of 0x3C
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (8'h3C >> i) & 8'h01;
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    checkOutput("busy_before_reset", {30'd0, bps_start, rx_int}, 32'd3);
    #5 rst_n = 1'b0;
    #1 checkOutput("reset_midframe", {20'd0, bps_start, rx_int, rx_done, frame_err, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("after_reset_idle", {20'd0, bps_start, rx_int, rx_done, frame_err, rx_data}, 32'd0);

    applyStimulus(8'hC3, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("final_rx_data", {24'd0, rx_data}, 32'hC3);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
